// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: one transmitter, one 2-flop-synchronized receiver, CLKS_PER_BIT clocks per bit.
// Latency: tx_busy/start bit one edge after wr_en; rdy about 9.5 bits + 3 clocks after the rx start edge.
// No backpressure: wr_en is ignored while busy; rdy is sticky, and a new byte overwrites dout. UART_LOOPBACK_EN feeds tx into the receiver.
`timescale 1ns/1ps
module uart_core #(
    parameter int CLK_FREQ_HZ  = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       wr_en,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic       rdy,
    input  logic       rdy_clr,
    output logic [7:0] dout
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e          tx_state_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [2:0]      tx_idx_q;
    logic [7:0]      tx_shift_q;
    logic            tx_q;
    logic            tx_busy_q;

    state_e          rx_state_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      rx_idx_q;
    logic [7:0]      rx_shift_q;
    logic            rx_meta_q;
    logic            rx_sync_q;
    logic            rx_prev_q;
    logic [7:0]      dout_q;
    logic            rdy_q;
    logic            rx_src;

`ifdef UART_LOOPBACK_EN
    logic unused_rx;
    assign rx_src    = tx_q;
    assign unused_rx = rx;
`else
    assign rx_src = rx;
`endif

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            case (tx_state_q)
                S_IDLE: begin
                    if (wr_en) begin
                        tx_shift_q <= din;
                        tx_q       <= 1'b0;
                        tx_busy_q  <= 1'b1;
                        tx_cnt_q   <= '0;
                        tx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                        tx_state_q <= S_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q <= '0;
                        if (tx_idx_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= S_STOP;
                        end else begin
                            tx_idx_q <= tx_idx_q + 3'd1;
                            tx_q     <= tx_shift_q[tx_idx_q + 3'd1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q   <= '0;
                        tx_busy_q  <= 1'b0;
                        tx_state_q <= S_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    // rdy_clr is applied first so a byte completing on the same edge wins.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            dout_q     <= '0;
            rdy_q      <= 1'b0;
        end else begin
            rx_meta_q <= rx_src;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            if (rdy_clr) rdy_q <= 1'b0;
            case (rx_state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt_q == HALF_END) begin
                        rx_cnt_q <= '0;
                        rx_idx_q <= '0;
                        rx_state_q <= rx_sync_q ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q             <= '0;
                        rx_shift_q[rx_idx_q] <= rx_sync_q;
                        if (rx_idx_q == 3'd7) rx_state_q <= S_STOP;
                        else                  rx_idx_q   <= rx_idx_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= S_IDLE;
                        if (rx_sync_q) begin
                            dout_q <= rx_shift_q;
                            rdy_q  <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;
    assign rdy     = rdy_q;
    assign dout    = dout_q;
endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: bit time scaled to 86 clocks (10 MHz / 115200, truncated) to keep runs short.
`timescale 1ns/1ps
module tb_uart_core;
    localparam int CLK_FREQ_HZ = 10000000;
    localparam int BAUD        = 115200;
    localparam int CPB         = CLK_FREQ_HZ / BAUD;

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] din     = 8'h00;
    logic       wr_en   = 1'b0;
    logic       rx      = 1'b1;
    logic       rdy_clr = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       rdy;
    logic [7:0] dout;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    bit         tx_mon_en   = 1'b0;
    bit         rx_mon_busy = 1'b0;

    uart_core #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD(BAUD)) dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .din(din), .wr_en(wr_en),
        .tx(tx), .tx_busy(tx_busy), .rx(rx), .rdy(rdy),
        .rdy_clr(rdy_clr), .dout(dout)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decodes every frame seen on tx at mid-bit and scores it against tx_exp.
    task automatic tx_monitor();
        logic [7:0] got;
        forever begin
            @(negedge clk_50m);
            if (tx_mon_en && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk_50m);
                check("tx_start_bit", 32'(tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk_50m);
                    got[i] = tx;
                end
                repeat (CPB) @(negedge clk_50m);
                check("tx_stop_bit", 32'(tx), 32'd1);
                check("tx_queue_nonempty", 32'(tx_exp.size() > 0), 32'd1);
                if (tx_exp.size() > 0) check("tx_byte", 32'(got), 32'(tx_exp.pop_front()));
            end
        end
    endtask

    // Scores each rdy against rx_exp, confirms stickiness, then clears it.
    task automatic rx_monitor();
        logic [7:0] exp;
        forever begin
            @(negedge clk_50m);
            if (rdy === 1'b1) begin
                rx_mon_busy = 1'b1;
                check("rx_queue_nonempty", 32'(rx_exp.size() > 0), 32'd1);
                exp = (rx_exp.size() > 0) ? rx_exp.pop_front() : dout;
                check("rx_dout", 32'(dout), 32'(exp));
                repeat (3) @(negedge clk_50m);
                check("rdy_sticky", 32'(rdy), 32'd1);
                rdy_clr = 1'b1;
                @(negedge clk_50m);
                rdy_clr = 1'b0;
                check("rdy_cleared", 32'(rdy), 32'd0);
                check("dout_hold", 32'(dout), 32'(exp));
                rx_mon_busy = 1'b0;
            end
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where tx_busy falls.
    task automatic send_tx(input logic [7:0] b, input bit inject, input bit loop_exp);
        int n;
        din   = b;
        wr_en = 1'b1;
        tx_exp.push_back(b);
`ifdef UART_LOOPBACK_EN
        if (loop_exp) rx_exp.push_back(b);
`else
        if (loop_exp) n = 0;
`endif
        @(posedge clk_50m); #1;
        wr_en = 1'b0;
        din   = ~b;
        check("busy_rise", 32'(tx_busy), 32'd1);
        check("tx_start_now", 32'(tx), 32'd0);
        n = 0;
        while (tx_busy === 1'b1 && n < 11 * CPB) begin
            @(posedge clk_50m); #1;
            n++;
            if (inject && n == 3 * CPB) begin
                din   = 8'h3C;
                wr_en = 1'b1;
            end else begin
                wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
        check("busy_length", 32'(n), 32'(10 * CPB));
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (CPB) @(posedge clk_50m); #1;
        end
        rx = 1'b1;
    endtask

    task automatic wait_rx_drain();
        int n = 0;
        while ((rx_exp.size() != 0 || rx_mon_busy) && n < 12 * CPB) begin
            @(posedge clk_50m); #1;
            n++;
        end
        check("rx_drained", 32'(rx_exp.size()), 32'd0);
    endtask

    task automatic rx_random(input int cnt);
        logic [7:0] b;
        for (int i = 0; i < cnt; i++) begin
            b = 8'($urandom_range(0, 255));
            rx_exp.push_back(b);
            drive_rx(b, 1'b1);
        end
    endtask

    task automatic tx_random(input int cnt);
        for (int i = 0; i < cnt; i++) send_tx(8'($urandom_range(0, 255)), 1'b0, 1'b1);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        fork
            tx_monitor();
            rx_monitor();
        join_none
        repeat (3) @(posedge clk_50m); #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(tx_busy), 32'd0);
        check("reset_rdy", 32'(rdy), 32'd0);
        check("reset_dout", 32'(dout), 32'h00);
        rst_n = 1'b1;
        @(posedge clk_50m); #1;
        tx_mon_en = 1'b1;

        send_tx(8'h55, 1'b0, 1'b1);
        wait_rx_drain();

`ifndef UART_LOOPBACK_EN
        rx_exp.push_back(8'hA5);
        drive_rx(8'hA5, 1'b1);
        wait_rx_drain();
        check("a5_dout_after_clr", 32'(dout), 32'hA5);
        check("a5_rdy_after_clr", 32'(rdy), 32'd0);
`endif

        send_tx(8'hC3, 1'b1, 1'b1);
        repeat (5) @(posedge clk_50m); #1;
        check("no_second_frame", 32'(tx_busy), 32'd0);
        wait_rx_drain();

`ifndef UART_LOOPBACK_EN
        drive_rx(8'hFF, 1'b0);
        repeat (CPB) @(posedge clk_50m); #1;
        check("frame_err_rdy", 32'(rdy), 32'd0);
        check("frame_err_dout", 32'(dout), 32'hA5);
        rx_exp.push_back(8'h12);
        drive_rx(8'h12, 1'b1);
        wait_rx_drain();
        check("after_err_dout", 32'(dout), 32'h12);

        rx = 1'b0;
        repeat (CPB / 4) @(posedge clk_50m); #1;
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk_50m); #1;
        check("glitch_rdy", 32'(rdy), 32'd0);
        rx_exp.push_back(8'h81);
        drive_rx(8'h81, 1'b1);
        wait_rx_drain();
`endif

        tx_mon_en = 1'b0;
        din   = 8'h0F;
        wr_en = 1'b1;
        @(posedge clk_50m); #1;
        wr_en = 1'b0;
        repeat (2 * CPB + 7) @(posedge clk_50m);
        #5;
        rst_n = 1'b0;
        #1;
        check("midreset_tx", 32'(tx), 32'd1);
        check("midreset_busy", 32'(tx_busy), 32'd0);
        check("midreset_dout", 32'(dout), 32'h00);
        @(posedge clk_50m); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk_50m); #1;
        check("post_reset_busy", 32'(tx_busy), 32'd0);
        check("post_reset_rdy", 32'(rdy), 32'd0);
        tx_mon_en = 1'b1;

`ifdef UART_LOOPBACK_EN
        tx_random(20);
`else
        fork
            rx_random(20);
            tx_random(20);
        join
`endif
        wait_rx_drain();
        repeat (CPB) @(posedge clk_50m); #1;
        check("tx_queue_empty", 32'(tx_exp.size()), 32'd0);
        check("rx_queue_empty", 32'(rx_exp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
